leaky_relu_grad: RTL

Backward-pass companion to the Leaky ReLU activation. It records the sign mask of each forward activation input in an in-order buffer. It then consumes an upstream gradient stream and emits dx = g for each element whose forward input was positive, or dx = g·2^-SHIFT otherwise. It sits beside the forward Leaky ReLU in the tile datapath, and all three streams use valid/ready handshakes.

---
 rtl/leaky_relu_grad.sv | 130 +++++++++++++
 1 files changed

// File: rtl/leaky_relu_grad.sv
// leaky_relu_grad: backward pass of Leaky ReLU.
// Forward inputs push a sign mask (x > 0) into an in-order buffer. Each upstream
// gradient pops one mask and produces dx = g (mask set) or g scaled by 2^-SHIFT
// (mask clear) into a single output register with valid/ready handshake.
// Optional build macro LRELU_GRAD_ROUND_EN: round-to-nearest (ties toward +inf)
// on the leak path instead of a plain floor shift.
module leaky_relu_grad #(
  parameter int DEPTH = 16,
  parameter int SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd_valid,
  input  logic [7:0]               fwd_x,
  output logic                     fwd_ready,
  input  logic                     bwd_valid,
  input  logic [7:0]               bwd_g,
  output logic                     bwd_ready,
  output logic                     out_valid,
  output logic [7:0]               out_dx,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DEPTH-1:0] mask_q, mask_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_dx_q, out_dx_d;

  logic             push, pop;
  logic             push_m;
  logic             pop_m;
  logic [7:0]       leak_dx;

  // Ready signals derive from registered state; bwd_ready also sees out_ready
  // so a drained output register can be refilled in the same cycle.
  assign fwd_ready = (level_q != FULL_LVL);
  assign bwd_ready = (level_q != '0) & (~out_valid_q | out_ready);

  assign push   = fwd_valid & fwd_ready;
  assign pop    = bwd_valid & bwd_ready;

  // Positive means sign clear and nonzero; zero takes the leak slope.
  assign push_m = ~fwd_x[7] & (|fwd_x[6:0]);
  assign pop_m  = mask_q[rd_ptr_q];

`ifdef LRELU_GRAD_ROUND_EN
  localparam int            HALF_I = 1 << (SHIFT - 1);
  localparam logic [8:0]    HALF   = HALF_I[8:0];

  logic signed [8:0] g_ext;
  logic signed [8:0] g_sum;
  logic signed [8:0] g_shr;

  // Add half an LSB of the scaled result in 9 bits, then shift arithmetically.
  always_comb begin
    g_ext   = {bwd_g[7], bwd_g};
    g_sum   = g_ext + $signed(HALF);
    g_shr   = g_sum >>> SHIFT;
    leak_dx = g_shr[7:0];
  end
`else
  logic signed [7:0] g_s;

  // Plain arithmetic shift: floor toward -inf.
  always_comb begin
    g_s     = bwd_g;
    leak_dx = g_s >>> SHIFT;
  end
`endif

  // Next-state: mask write, pointer advance, occupancy and output register.
  always_comb begin
    mask_d      = mask_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_dx_d    = out_dx_q;

    if (push) begin
      mask_d[wr_ptr_q] = push_m;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_valid_d = 1'b1;
      out_dx_d    = pop_m ? bwd_g : leak_dx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers with synchronous reset; reset drops all stored masks.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_dx_q    <= '0;
    end else begin
      mask_q      <= mask_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_dx_q    <= out_dx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dx    = out_dx_q;
  assign level     = level_q;

endmodule
